// File: rtl/comb_filter_core.sv
// ADC128S022-style SPI acquisition feeding a feedforward/feedback comb filter
// with a circular delay line; emits a saturated offset-binary DAC word per frame.
module comb_filter_core #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned DELAY      = 100,
    parameter int unsigned GAIN_SHIFT = 1,
    parameter int unsigned MODE       = 0,
    parameter int unsigned SUB        = 0,
    parameter logic [2:0]  CHANNEL    = 3'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic             ADC_SCLK,
    output logic             ADC_CS_N,
    output logic             ADC_SADDR,
    input  logic             ADC_SDAT,
    output logic [OUT_W-1:0] dac_out,
    output logic             dac_valid
);

    localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PTR_W  = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int unsigned FILL_W = $clog2(DELAY + 1);
    localparam logic [15:0] CMD    = {2'b00, CHANNEL, 11'b0};
    localparam logic [OUT_W-1:0] DAC_MID = OUT_W'(1) << (OUT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_STOP,
        S_CALC,
        S_OUT
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [3:0]                bit_cnt;
    logic [14:0]               tx;
    logic [DATA_W-1:0]         rx;
    logic [PTR_W-1:0]          ptr;
    logic [FILL_W-1:0]         fill;
    logic [OUT_W-1:0]          dac_hold;
    logic signed [DATA_W-1:0]  mem [DELAY];

    logic                      half_done;
    logic signed [DATA_W-1:0]  xs;
    logic signed [DATA_W-1:0]  tap;
    logic signed [DATA_W-1:0]  term;
    logic signed [DATA_W:0]    sum;
    logic signed [DATA_W-1:0]  y_sat;
    logic signed [DATA_W-1:0]  wr_data;
    logic [OUT_W-1:0]          y_top;

    assign half_done = (cnt == CNT_W'(CLK_DIV - 1));

    // Filter datapath; tap is suppressed until the delay line has been filled once.
    always_comb begin
        xs    = {~rx[DATA_W-1], rx[DATA_W-2:0]};
        tap   = (fill == FILL_W'(DELAY)) ? mem[ptr] : '0;
        term  = tap >>> GAIN_SHIFT;
        if (SUB != 0) begin
            sum = {xs[DATA_W-1], xs} - {term[DATA_W-1], term};
        end else begin
            sum = {xs[DATA_W-1], xs} + {term[DATA_W-1], term};
        end
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            y_sat = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            y_sat = sum[DATA_W-1:0];
        end
        wr_data = (MODE != 0) ? y_sat : xs;
        y_top   = y_sat[DATA_W-1 -: OUT_W];
    end

    // Delay line storage; written once per frame after the tap has been read.
    always_ff @(posedge clk) begin
        if (state == S_CALC) begin
            mem[ptr] <= wr_data;
        end
    end

    // Frame sequencer, SPI shifting and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            tx        <= '0;
            rx        <= '0;
            ptr       <= '0;
            fill      <= '0;
            dac_hold  <= DAC_MID;
            ADC_SCLK  <= 1'b1;
            ADC_CS_N  <= 1'b1;
            ADC_SADDR <= 1'b0;
            dac_out   <= DAC_MID;
            dac_valid <= 1'b0;
        end else begin
            dac_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state     <= S_START;
                        cnt       <= '0;
                        ADC_CS_N  <= 1'b0;
                        ADC_SADDR <= CMD[15];
                        tx        <= CMD[14:0];
                    end
                end
                S_START: begin
                    if (half_done) begin
                        state    <= S_SHIFT;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        ADC_SCLK <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (!half_done) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (!ADC_SCLK) begin
                            ADC_SCLK <= 1'b1;
                            rx       <= {rx[DATA_W-2:0], ADC_SDAT};
                        end else if (bit_cnt == 4'd15) begin
                            state     <= S_STOP;
                            ADC_CS_N  <= 1'b1;
                            ADC_SADDR <= 1'b0;
                        end else begin
                            // Bit 15 went out at CS_N fall, so later falls advance the command.
                            bit_cnt   <= bit_cnt + 4'd1;
                            ADC_SCLK  <= 1'b0;
                            ADC_SADDR <= tx[14];
                            tx        <= {tx[13:0], 1'b0};
                        end
                    end
                end
                S_STOP: begin
                    if (half_done) begin
                        state <= S_CALC;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_CALC: begin
                    state    <= S_OUT;
                    dac_hold <= y_top ^ DAC_MID;
                    ptr      <= (ptr == PTR_W'(DELAY - 1)) ? '0 : ptr + PTR_W'(1);
                    if (fill != FILL_W'(DELAY)) begin
                        fill <= fill + FILL_W'(1);
                    end
                end
                S_OUT: begin
                    dac_out   <= dac_hold;
                    dac_valid <= 1'b1;
                    if (enable) begin
                        state     <= S_START;
                        cnt       <= '0;
                        ADC_CS_N  <= 1'b0;
                        ADC_SADDR <= CMD[15];
                        tx        <= CMD[14:0];
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
